// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory and queues in-order responses for the downstream datapath.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic          running_q, running_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] kept_q, kept_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];

    logic          req_valid_s, acc_s, resp_s, drop_hit_s, push_s, pop_s;
    logic [SW-1:0] kc_sum_s, kd_sum_s;
    logic          unused_ok_s;

    assign unused_ok_s = ^redirect_pc[1:0];

    // Handshake qualifiers; issue credit depends on registered state only.
    always_comb begin
        kc_sum_s    = SW'(kept_q) + SW'(cnt_q);
        kd_sum_s    = SW'(kept_q) + SW'(drop_q);
        req_valid_s = running_q && (kc_sum_s < SW'(DEPTH)) && (kd_sum_s < SW'(DEPTH));
        acc_s       = req_valid_s && imem_req_ready;
        resp_s      = imem_resp_valid && ((kept_q != CW'(0)) || (drop_q != CW'(0)));
        drop_hit_s  = resp_s && (drop_q != CW'(0));
        push_s      = resp_s && !drop_hit_s && !redirect_valid;
        pop_s       = (cnt_q != CW'(0)) && inst_ready && !redirect_valid;
    end

    // Next-state: redirect flushes the queue and moves every in-flight request to the drop pool.
    always_comb begin
        running_d   = 1'b1;
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        kept_d      = kept_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            kept_d     = CW'(0);
            drop_d     = drop_q + kept_q + CW'(acc_s) - CW'(resp_s);
            cnt_d      = CW'(0);
            rd_ptr_d   = PW'(0);
            wr_ptr_d   = PW'(0);
        end else begin
            if (acc_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            kept_d = kept_q + CW'(acc_s) - CW'(resp_s && !drop_hit_s);
            drop_d = drop_q - CW'(drop_hit_s);
            cnt_d  = cnt_q + CW'(push_s) - CW'(pop_s);
            if (push_s) begin
                pc_mem_d[wr_ptr_q]    = resp_pc_q;
                instr_mem_d[wr_ptr_q] = imem_resp_data;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                resp_pc_d             = resp_pc_q + 32'd4;
            end else begin
                wr_ptr_d  = wr_ptr_q;
                resp_pc_d = resp_pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_q   <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            kept_q      <= CW'(0);
            drop_q      <= CW'(0);
            cnt_q       <= CW'(0);
            rd_ptr_q    <= PW'(0);
            wr_ptr_q    <= PW'(0);
            pc_mem_q    <= '{default: RESET_PC};
            instr_mem_q <= '{default: 32'h0000_0000};
        end else begin
            running_q   <= running_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            kept_q      <= kept_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = (cnt_q != CW'(0));
    assign inst_data      = instr_mem_q[rd_ptr_q];
    assign inst_pc        = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Randomized bench for riscv_fetch_unit against a queue-based reference model
// that tracks each in-flight request individually as live or stale.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          D      = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_data, inst_pc;

    always #5 clk = ~clk;

    riscv_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: each in-flight request is an entry (1 = stale), FIFO holds {pc, instr}.
    bit          m_running;
    logic [31:0] m_fetch_pc, m_resp_pc;
    bit          m_inflight[$];
    logic [63:0] m_fifo[$];

    // Memory model: in-order responses, each scheduled for a given cycle.
    int          pend_due[$];
    logic [31:0] pend_addr[$];
    int          lat_min = 1, lat_max = 1, last_due = 0;
    bit          stray = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic run_cycle(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        bit          exp_valid, acc, resp, do_pop, consumed, stale;
        int          kept_n, due;
        logic [31:0] rdata, aligned;
        @(negedge clk);
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        resp  = 1'b0;
        rdata = $urandom;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            resp  = 1'b1;
            rdata = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end else if (stray) begin
            resp  = 1'b1;
            stray = 1'b0;
        end
        imem_resp_valid = resp;
        imem_resp_data  = rdata;
        kept_n = 0;
        foreach (m_inflight[i]) if (!m_inflight[i]) kept_n++;
        exp_valid = m_running && (kept_n + m_fifo.size() < D) && (m_inflight.size() < D);
        #1;
        check_eq("req_valid", imem_req_valid, exp_valid);
        check_eq("req_addr", imem_req_addr, m_fetch_pc);
        check_eq("inst_valid", inst_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            check_eq("inst_pc", inst_pc, m_fifo[0][63:32]);
            check_eq("inst_data", inst_data, m_fifo[0][31:0]);
        end
        acc     = exp_valid && rdy;
        do_pop  = (m_fifo.size() != 0) && irdy && !redir;
        aligned = {rpc[31:2], 2'b00};
        @(posedge clk);
        #1;
        if (acc) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_due.push_back(due);
            pend_addr.push_back(m_fetch_pc);
        end
        consumed = 1'b0;
        stale    = 1'b1;
        if (resp && m_inflight.size() != 0) begin
            consumed = 1'b1;
            stale    = m_inflight.pop_front();
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (consumed && !stale && !redir) begin
            m_fifo.push_back({m_resp_pc, rdata});
            m_resp_pc = m_resp_pc + 32'd4;
        end
        if (redir) begin
            foreach (m_inflight[i]) m_inflight[i] = 1'b1;
            m_fifo.delete();
            if (acc) m_inflight.push_back(1'b1);
            m_fetch_pc = aligned;
            m_resp_pc  = aligned;
        end else if (acc) begin
            m_inflight.push_back(1'b0);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        m_running = 1'b1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("rst_req_valid", imem_req_valid, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RST_PC);
        check_eq("rst_inst_valid", inst_valid, 32'd0);
        check_eq("rst_inst_data", inst_data, 32'd0);
        check_eq("rst_inst_pc", inst_pc, RST_PC);
        m_running  = 1'b0;
        m_fetch_pc = RST_PC;
        m_resp_pc  = RST_PC;
        m_inflight.delete();
        m_fifo.delete();
        pend_due.delete();
        pend_addr.delete();
        last_due = cyc;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        stray   = 1'b1;
    endtask

    initial begin
        bit seen;
        do_reset();

        // Reset and stream: one instruction per cycle after a 2-cycle fill.
        lat_min = 1; lat_max = 1;
        repeat (3) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("stream_first_pc", inst_pc, RST_PC);
        for (int i = 0; i < 16; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            check_eq("stream_valid", inst_valid, 32'd1);
            check_eq("stream_pc", inst_pc, RST_PC + 32'd4 * (i + 1));
        end

        // Backpressure: queue fills, issue stops, then drains in order.
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0000);
        repeat (12) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("bp_stalled", imem_req_valid, 32'd0);
        check_eq("bp_head_pc", inst_pc, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            check_eq("bp_drain_pc", inst_pc, 32'd4 * (i + 1));
        end

        // Redirect with in-flight work at 3-cycle latency.
        lat_min = 3; lat_max = 3;
        repeat (2) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002);
        check_eq("redir_addr", imem_req_addr, 32'h0000_2000);
        check_eq("redir_inst_valid", inst_valid, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (!seen && inst_valid) begin
                seen = 1'b1;
                check_eq("redir_first_pc", inst_pc, 32'h0000_2000);
            end
        end
        check_eq("redir_seen", seen, 32'd1);

        // Redirect coinciding with accept, response and pop.
        lat_min = 1; lat_max = 1;
        repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_4000);
        check_eq("simul_empty", inst_valid, 32'd0);
        check_eq("simul_addr", imem_req_addr, 32'h0000_4000);
        repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap-around.
        run_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        check_eq("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr1", imem_req_addr, 32'h0000_0000);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (!seen && inst_valid) begin
                seen = 1'b1;
                check_eq("wrap_first_pc", inst_pc, 32'hFFFF_FFFC);
            end
        end
        check_eq("wrap_seen", seen, 32'd1);

        // Randomized traffic with random latency, stalls and redirects.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 11) == 0, tgt);
        end

        // Reset mid-operation with a full queue.
        lat_min = 1; lat_max = 1;
        repeat (12) run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("full_before_rst", inst_valid, 32'd1);
        do_reset();
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("restart_valid", imem_req_valid, 32'd1);
        check_eq("restart_addr", imem_req_addr, RST_PC);
        for (int i = 0; i < 200; i++) begin
            run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                      $urandom_range(0, 15) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
